// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Handshake and operand/result bundle for serial_subtractor.
//               The overflow signal exists only when SERIAL_SUB_OVF_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  // Requester side: issues operands and observes status/results
  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
    , input overflow
`endif
  );

  // Subtractor side
  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
    , output overflow
`endif
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//               diff = a - b mod 2^WIDTH, borrow = (a < b).
//               Optional signed overflow flag: define SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             overflow_q, overflow_d;
`endif

  // One full-subtractor cell fed from the operand shift registers
  logic w_ai, w_bi, w_d, w_bout;
  assign w_ai   = a_sr_q[0];
  assign w_bi   = b_sr_q[0];
  assign w_d    = w_ai ^ w_bi ^ borrow_q;
  assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & borrow_q);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    overflow_d = overflow_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        diff_d   = {w_d, diff_q[WIDTH-1:1]};
        borrow_d = w_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == C_LAST_BIT) begin
          state_d = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
          // w_d is the result MSB on the final bit-cycle
          overflow_d = (a_msb_q != b_msb_q) && (w_d != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.overflow = overflow_q;
`endif

endmodule
`default_nettype wire
